memref_rd_sweep: RTL and testbench

MEMREF_RD_SWEEP -- requirements
Module: memref_rd_sweep

---
 rtl/memref_rd_sweep_pkg.sv | 21 ++
 rtl/memref_rd_sweep.sv | 117 +++++++++++
 tb/tb_memref_rd_sweep.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/memref_rd_sweep_pkg.sv
// memref_tb_pkg
//   Shared types and helpers for the memref_rd_sweep read sequencer.
//   - state_t       : sequencer state encoding
//   - wrap_next_addr: next word address with wrap at an arbitrary depth
package memref_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Explicit compare rather than a power-of-two mask so non-2^n depths wrap
  // from size-1 back to 0.
  function automatic int unsigned wrap_next_addr(input int unsigned a,
                                                 input int unsigned size);
    return (a >= size - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/memref_rd_sweep.sv
// memref_rd_sweep
//   Issues `count` back-to-back reads starting at `base` (wrapping modulo
//   SIZE) to an attached single-cycle-latency read port, accumulates a
//   wrapping checksum of the returned words and flags protocol errors.
//
//   state  | meaning
//   IDLE   | waiting for tstart; results of the last sweep held
//   ISSUE  | one read request per cycle, count cycles
//   DRAIN  | one cycle for the last response to arrive
//   DONE   | one-cycle done pulse, results final
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   tstart, base,count: start pulse and sweep parameters (sampled in IDLE)
//   rd_en, addr       : read request to the read port
//   dout_valid, dout  : read response from the read port
//   busy, done        : status (busy in ISSUE/DRAIN, done pulse in DONE)
//   checksum, rd_count: accumulated sum and number of accepted responses
//   err               : sticky protocol-error flag
module memref_rd_sweep
  import memref_tb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8,
  localparam int AW   = $clog2(SIZE),
  localparam int CW   = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tstart,
  input  logic [AW-1:0]    base,
  input  logic [CW-1:0]    count,
  output logic             rd_en,
  output logic [AW-1:0]    addr,
  input  logic             dout_valid,
  input  logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] checksum,
  output logic [CW-1:0]    rd_count,
  output logic             err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic [CW-1:0]    r_left;
  logic             r_pending;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [AW-1:0]    w_addr_nxt;
  logic             w_start;

  assign w_addr_nxt = AW'(wrap_next_addr(32'(r_addr), SIZE));
  assign w_start    = (r_state == ST_IDLE) && tstart;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (tstart) w_state_nxt = (count == '0) ? ST_DRAIN : ST_ISSUE;
      // r_left is the number of reads still to issue including this cycle
      ST_ISSUE: if (r_left == CW'(1)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_left    <= '0;
      r_pending <= 1'b0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= (r_state == ST_ISSUE);
      if (w_start) begin
        r_addr <= base;
        r_left <= count;
        r_sum  <= '0;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end else begin
        if (r_state == ST_ISSUE) begin
          r_addr <= w_addr_nxt;
          r_left <= r_left - CW'(1);
        end
        // Response checking is off in IDLE so that a response still in
        // flight from a sweep aborted by reset is silently dropped.
        if (r_state != ST_IDLE) begin
          if (r_pending && dout_valid) begin
            r_sum <= r_sum + dout;
            r_cnt <= r_cnt + CW'(1);
          end
          if (r_pending != dout_valid) r_err <= 1'b1;
        end
      end
    end
  end

  assign rd_en    = (r_state == ST_ISSUE);
  assign busy     = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_DONE);
  assign addr     = r_addr;
  assign checksum = r_sum;
  assign rd_count = r_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_memref_rd_sweep.sv
// tb_memref_rd_sweep
//   Directed bench for memref_rd_sweep with SIZE=8, WIDTH=32 and a
//   behavioural one-cycle-latency read port holding mem[i]=i+1.
module tb_memref_rd_sweep;

  localparam int WIDTH = 32;
  localparam int SIZE  = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tstart = 1'b0;
  logic [AW-1:0]    base = '0;
  logic [CW-1:0]    count = '0;
  logic             rd_en;
  logic [AW-1:0]    addr;
  logic             dout_valid;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] checksum;
  logic [CW-1:0]    rd_count;
  logic             err;

  logic [WIDTH-1:0] mem [SIZE];
  logic             drop_en = 1'b0;
  logic [AW-1:0]    drop_addr = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  memref_rd_sweep #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .tstart(tstart), .base(base), .count(count),
    .rd_en(rd_en), .addr(addr), .dout_valid(dout_valid), .dout(dout),
    .busy(busy), .done(done), .checksum(checksum), .rd_count(rd_count),
    .err(err)
  );

  // Read port model: response one cycle after the request; optionally
  // swallows the response for one address to provoke a protocol error.
  always @(posedge clk) begin
    dout_valid <= rd_en && !(drop_en && (addr == drop_addr));
    dout       <= mem[addr];
  end

  typedef struct {
    int          b;
    int          c;
    bit          drop;
    int          daddr;
    bit          ff_mem;
    logic [31:0] exp_sum;
    int          exp_cnt;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic init_mem();
    for (int i = 0; i < SIZE; i++) mem[i] = 32'(i + 1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int seen_done;
    string tag;
    tag = $sformatf("v%0d", id);
    init_mem();
    if (v.ff_mem) begin
      mem[0] = 32'hFFFF_FFFF;
      mem[1] = 32'hFFFF_FFFF;
    end
    drop_en   = v.drop;
    drop_addr = AW'(v.daddr);
    @(negedge clk);
    base   = AW'(v.b);
    count  = CW'(v.c);
    tstart = 1'b1;
    @(posedge clk); #1;
    tstart = 1'b0;
    seen_done = -1;
    for (int cyc = 0; cyc < v.c + 4; cyc++) begin
      @(negedge clk);
      chk({tag, " rd_en"}, 64'(rd_en), 64'(cyc < v.c));
      if (cyc < v.c) chk({tag, " addr"}, 64'(addr), 64'((v.b + cyc) % SIZE));
      chk({tag, " busy"}, 64'(busy), 64'(cyc <= v.c));
      chk({tag, " done"}, 64'(done), 64'(cyc == v.exp_done));
      if (done && seen_done < 0) seen_done = cyc;
      if (cyc == v.exp_done) begin
        chk({tag, " checksum"}, 64'(checksum), 64'(v.exp_sum));
        chk({tag, " rd_count"}, 64'(rd_count), 64'(v.exp_cnt));
        chk({tag, " err"}, 64'(err), 64'(v.exp_err));
      end
    end
    chk({tag, " done_cycle"}, 64'(seen_done), 64'(v.exp_done));
    // Results must hold in IDLE
    chk({tag, " hold_sum"}, 64'(checksum), 64'(v.exp_sum));
    chk({tag, " hold_cnt"}, 64'(rd_count), 64'(v.exp_cnt));
    chk({tag, " hold_err"}, 64'(err), 64'(v.exp_err));
    drop_en = 1'b0;
    init_mem();
  endtask

  vec_t vecs [6];

  initial begin
    int seen_done;
    vec_t vr;

    vecs[0] = '{b:0, c:8, drop:0, daddr:0, ff_mem:0, exp_sum:32'd36,         exp_cnt:8, exp_err:0, exp_done:9};
    vecs[1] = '{b:6, c:4, drop:0, daddr:0, ff_mem:0, exp_sum:32'd18,         exp_cnt:4, exp_err:0, exp_done:5};
    vecs[2] = '{b:0, c:0, drop:0, daddr:0, ff_mem:0, exp_sum:32'd0,          exp_cnt:0, exp_err:0, exp_done:1};
    vecs[3] = '{b:0, c:2, drop:0, daddr:0, ff_mem:1, exp_sum:32'hFFFF_FFFE,  exp_cnt:2, exp_err:0, exp_done:3};
    vecs[4] = '{b:0, c:4, drop:1, daddr:1, ff_mem:0, exp_sum:32'd8,          exp_cnt:3, exp_err:1, exp_done:5};
    vecs[5] = '{b:3, c:5, drop:0, daddr:0, ff_mem:0, exp_sum:32'd30,         exp_cnt:5, exp_err:0, exp_done:6};

    init_mem();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst rd_en", 64'(rd_en), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    chk("rst checksum", 64'(checksum), 64'(0));
    chk("rst rd_count", 64'(rd_count), 64'(0));
    chk("rst addr", 64'(addr), 64'(0));

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // tstart during DONE is ignored
    @(negedge clk);
    base = 3'd0; count = 4'd1; tstart = 1'b1;
    @(posedge clk); #1 tstart = 1'b0;   // cycle 0
    @(posedge clk); #1;                 // cycle 1
    @(posedge clk); #1;                 // cycle 2 (DONE)
    base = 3'd4; count = 4'd3; tstart = 1'b1;
    @(negedge clk);
    chk("dn_start done", 64'(done), 64'(1));
    @(posedge clk); #1 tstart = 1'b0;   // cycle 3
    @(negedge clk);
    chk("dn_start busy", 64'(busy), 64'(0));
    chk("dn_start rd_en", 64'(rd_en), 64'(0));
    chk("dn_start checksum", 64'(checksum), 64'(1));
    repeat (2) @(negedge clk);
    chk("dn_start idle", 64'(busy), 64'(0));

    // Reset mid-sweep with an ignored second start
    @(negedge clk);
    base = 3'd0; count = 4'd8; tstart = 1'b1;
    @(posedge clk); #1 tstart = 1'b0;   // cycle 0
    @(posedge clk); #1;                 // cycle 1
    base = 3'd5; count = 4'd2; tstart = 1'b1;
    @(negedge clk);
    chk("rs addr c1", 64'(addr), 64'(1));
    @(posedge clk); #1 tstart = 1'b0;   // cycle 2
    @(negedge clk);
    chk("rs addr c2", 64'(addr), 64'(2));
    @(posedge clk); #1 rst = 1'b1;      // cycle 3
    @(negedge clk);
    chk("rs addr c3", 64'(addr), 64'(3));
    @(posedge clk); #1 rst = 1'b0;      // cycle 4
    @(negedge clk);
    chk("rs rd_en", 64'(rd_en), 64'(0));
    chk("rs busy", 64'(busy), 64'(0));
    chk("rs addr", 64'(addr), 64'(0));
    chk("rs checksum", 64'(checksum), 64'(0));
    chk("rs rd_count", 64'(rd_count), 64'(0));
    chk("rs err c4", 64'(err), 64'(0));
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || rd_en) seen_done = 1;
    end
    chk("rs no_done", 64'(seen_done), 64'(0));
    chk("rs err", 64'(err), 64'(0));
    chk("rs checksum2", 64'(checksum), 64'(0));
    vr = '{b:2, c:3, drop:0, daddr:0, ff_mem:0, exp_sum:32'd12, exp_cnt:3, exp_err:0, exp_done:4};
    run_vec(vr, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
